// File: rtl/deserialize.sv
// deserialize - serial-to-parallel receiver (SIPO).
//
// Receive end of the parallel-load/shift serializer link. One serial bit is
// consumed per clock where serial_valid is high. Each completed WIDTH-bit
// word is presented on data_out (held until the next word completes),
// accompanied by a one-cycle data_valid strobe. A frame_start marker
// realigns the word boundary; if a partial word is discarded by it,
// framing_error pulses for one cycle.
//
// Parameters:
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: first received bit lands in data_out[WIDTH-1]
//              0: first received bit lands in data_out[0]
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          asynchronous, active-high; clears all state
//   serial_in      serial data bit, sampled when serial_valid=1
//   serial_valid   bit qualifier
//   frame_start    first bit of a new word (with serial_valid=1) or
//                  forced realignment (with serial_valid=0)
//   data_out       last completed word
//   data_valid     one-cycle pulse after the final bit of a word
//   busy           partial word in progress
//   framing_error  one-cycle pulse when a partial word is discarded
module deserialize #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             framing_error
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             framing_error_q, framing_error_d;
  logic [WIDTH-1:0] shifted;

  // Shift direction decides which end of the word the first bit ends up in.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {sr_q[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
      assign shifted = {serial_in, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sr_d            = sr_q;
    cnt_d           = cnt_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;

    if (serial_valid) begin
      sr_d = shifted;
      if (frame_start) begin
        // This bit starts a new word; any partial word is dropped, even if
        // it was one bit short of completing.
        cnt_d           = CNT_ONE;
        framing_error_d = (cnt_q != '0);
      end else if (cnt_q == CNT_LAST) begin
        data_out_d   = shifted;
        data_valid_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (frame_start) begin
      // Realign without consuming a bit; shift register contents are
      // irrelevant once the count restarts, so they simply hold.
      cnt_d           = '0;
      framing_error_d = (cnt_q != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q            <= '0;
      cnt_q           <= '0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      sr_q            <= sr_d;
      cnt_q           <= cnt_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (cnt_q != '0);

endmodule

// File: tb/tb_deserialize.sv
// Directed testbench for deserialize: one MSB-first and one LSB-first
// instance (WIDTH=4) sharing clock and reset. Expected words are queued
// when a word's stimulus is driven and popped when data_valid is seen.
module tb_deserialize;

  logic       clock;
  logic       reset;
  logic       m_sin, m_sv, m_fs;
  logic [3:0] m_data;
  logic       m_dv, m_busy, m_fe;
  logic       l_sin, l_sv, l_fs;
  logic [3:0] l_data;
  logic       l_dv, l_busy, l_fe;

  int n_checks = 0;
  int n_fails  = 0;

  logic [3:0] m_q[$];
  logic [3:0] l_q[$];
  logic [3:0] m_held = 4'h0;
  logic [3:0] l_held = 4'h0;

  deserialize #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset),
    .serial_in(m_sin), .serial_valid(m_sv), .frame_start(m_fs),
    .data_out(m_data), .data_valid(m_dv), .busy(m_busy),
    .framing_error(m_fe)
  );

  deserialize #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset),
    .serial_in(l_sin), .serial_valid(l_sv), .frame_start(l_fs),
    .data_out(l_data), .data_valid(l_dv), .busy(l_busy),
    .framing_error(l_fe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the selected instance (the other idles), then check
  // its outputs 1 time unit after the edge.
  task automatic step(input bit lsb, input logic sin, input logic sv,
                      input logic fs, input logic e_dv, input logic e_busy,
                      input logic e_fe, input string tag);
    if (lsb) begin
      l_sin = sin; l_sv = sv; l_fs = fs;
      m_sin = 1'b0; m_sv = 1'b0; m_fs = 1'b0;
    end else begin
      m_sin = sin; m_sv = sv; m_fs = fs;
      l_sin = 1'b0; l_sv = 1'b0; l_fs = 1'b0;
    end
    @(posedge clock);
    #1;
    if (lsb) begin
      chk({tag, "_dv"}, 32'(l_dv), 32'(e_dv));
      chk({tag, "_busy"}, 32'(l_busy), 32'(e_busy));
      chk({tag, "_ferr"}, 32'(l_fe), 32'(e_fe));
      if (e_dv) begin
        if (l_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $error("FAIL %s_sb: observed empty queue expected a word", tag);
        end else begin
          l_held = l_q.pop_front();
        end
      end
      chk({tag, "_data"}, 32'(l_data), 32'(l_held));
    end else begin
      chk({tag, "_dv"}, 32'(m_dv), 32'(e_dv));
      chk({tag, "_busy"}, 32'(m_busy), 32'(e_busy));
      chk({tag, "_ferr"}, 32'(m_fe), 32'(e_fe));
      if (e_dv) begin
        if (m_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $error("FAIL %s_sb: observed empty queue expected a word", tag);
        end else begin
          m_held = m_q.pop_front();
        end
      end
      chk({tag, "_data"}, 32'(m_data), 32'(m_held));
    end
    $display("step %s: lsb=%0b sin=%0b sv=%0b fs=%0b -> dv=%0b busy=%0b fe=%0b data=%h/%h",
             tag, lsb, sin, sv, fs, lsb ? l_dv : m_dv, lsb ? l_busy : m_busy,
             lsb ? l_fe : m_fe, m_data, l_data);
  endtask

  // Four contiguous bits, seq[3] sent first, frame_start on the first bit.
  task automatic word4(input bit lsb, input logic [3:0] seq,
                       input logic [3:0] exp_word, input string tag);
    if (lsb) l_q.push_back(exp_word);
    else     m_q.push_back(exp_word);
    step(lsb, seq[3], 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {tag, "_b0"});
    step(lsb, seq[2], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {tag, "_b1"});
    step(lsb, seq[1], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {tag, "_b2"});
    step(lsb, seq[0], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {tag, "_b3"});
  endtask

  task automatic idle(input bit lsb, input logic e_busy, input string tag);
    step(lsb, 1'b0, 1'b0, 1'b0, 1'b0, e_busy, 1'b0, tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_data"}, 32'(m_data), 32'h0);
    chk({tag, "_m_dv"}, 32'(m_dv), 32'h0);
    chk({tag, "_m_busy"}, 32'(m_busy), 32'h0);
    chk({tag, "_m_fe"}, 32'(m_fe), 32'h0);
    chk({tag, "_l_data"}, 32'(l_data), 32'h0);
    chk({tag, "_l_busy"}, 32'(l_busy), 32'h0);
    $display("reset check %s: m_data=%h l_data=%h", tag, m_data, l_data);
  endtask

  initial begin
    reset = 1'b0;
    m_sin = 1'b0; m_sv = 1'b0; m_fs = 1'b0;
    l_sin = 1'b0; l_sv = 1'b0; l_fs = 1'b0;
    #2 reset = 1'b1;
    #1 check_all_zero("por");
    @(posedge clock);
    #1 reset = 1'b0;

    // MSB-first: 1,0,1,1 -> 0xB, then 0,1,1,0 -> 0x6 back-to-back.
    word4(1'b0, 4'b1011, 4'hB, "m_w1");
    word4(1'b0, 4'b0110, 4'h6, "m_w2");
    idle(1'b0, 1'b0, "m_idle");

    // Gaps: 1,0,0,1 with three idle cycles between bits -> 0x9.
    m_q.push_back(4'h9);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "m_g0");
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1, "m_gap0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "m_g1");
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1, "m_gap1");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "m_g2");
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1, "m_gap2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "m_g3");

    // Misalignment: two stray bits, then frame_start with 0,1,1,1 -> 0x7.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "m_s0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "m_s1");
    m_q.push_back(4'h7);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "m_fs0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "m_fs1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "m_fs2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "m_fs3");

    // Realignment without a bit: one stray bit, then frame_start alone.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "m_r0");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "m_r1");
    // frame_start alone while aligned: no error.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "m_r2");

    // Reset mid-word, asserted between edges: outputs clear immediately.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "m_p0");
    #3 reset = 1'b1;
    #1 check_all_zero("mid");
    m_held = 4'h0;
    l_held = 4'h0;
    #2 reset = 1'b0;

    // LSB-first: 1,0,0,0 -> 0x1.
    word4(1'b1, 4'b1000, 4'h1, "l_w1");
    // Two bits, then reset, then fresh word 0,0,0,1 -> 0x8, no error.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "l_p0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "l_p1");
    #3 reset = 1'b1;
    #1 chk("l_rst_busy", 32'(l_busy), 32'h0);
    chk("l_rst_data", 32'(l_data), 32'h0);
    l_held = 4'h0;
    #2 reset = 1'b0;
    word4(1'b1, 4'b0001, 4'h8, "l_w2");
    idle(1'b1, 1'b0, "l_idle");

    chk("m_sb_empty", 32'(m_q.size()), 32'h0);
    chk("l_sb_empty", 32'(l_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  // Hard upper bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
